// File: rtl/rabbit_profile_loader.sv
// rtl/rabbit_profile_loader.sv - Rabbit serial profile loader: header count, fixed-size frames, slot writes
module rabbit_profile_loader #(
  parameter int MAX_PROF   = 20,
  parameter int FRAME_BITS = 184
) (
  input  logic                  ten_MHz_ext,
  input  logic                  key_2_reset,
  input  logic                  SCLK_PE_3,
  input  logic                  SDIO_PE_5,
  input  logic                  LOAD_PE_1,
  output logic                  wr_en,
  output logic [4:0]            wr_addr,
  output logic [0:FRAME_BITS-1] wr_data,
  output logic [4:0]            sweep_total,
  output logic                  load_done,
  output logic                  frame_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  logic [2:0]            state;
  logic [1:0]            sclk_sync, sdio_sync, load_sync;
  logic                  sclk_d, load_d;
  logic [7:0]            bit_cnt;
  logic [4:0]            frame_idx;
  logic [4:0]            n_prof;
  logic [0:FRAME_BITS-1] shift;

  logic                  sclk_rise, load_rise, load_s, sdio_s;
  logic [4:0]            hdr_next;
  logic [0:FRAME_BITS-1] frame_next;
  logic                  hdr_ok;

  assign sclk_rise  = sclk_sync[1] & ~sclk_d;
  assign load_rise  = load_sync[1] & ~load_d;
  assign load_s     = load_sync[1];
  assign sdio_s     = sdio_sync[1];
  assign hdr_next   = {n_prof[3:0], sdio_s};
  // Earlier bits migrate toward index 0, so the first bit received ends at wr_data[0].
  assign frame_next = {shift[1:FRAME_BITS-1], sdio_s};
  assign hdr_ok     = (hdr_next >= 5'd1) && (hdr_next <= 5'(MAX_PROF));

  always_ff @(posedge ten_MHz_ext or negedge key_2_reset) begin
    if (!key_2_reset) begin
      state       <= IDLE;
      sclk_sync   <= '0;
      sdio_sync   <= '0;
      load_sync   <= '0;
      sclk_d      <= 1'b0;
      load_d      <= 1'b0;
      bit_cnt     <= '0;
      frame_idx   <= '0;
      n_prof      <= '0;
      shift       <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      sweep_total <= '0;
      load_done   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], SCLK_PE_3};
      sdio_sync <= {sdio_sync[0], SDIO_PE_5};
      load_sync <= {load_sync[0], LOAD_PE_1};
      sclk_d    <= sclk_sync[1];
      load_d    <= load_sync[1];
      wr_en     <= 1'b0;
      load_done <= 1'b0;

      // A new session wins over everything, including a coincident SCLK edge.
      if (load_rise) begin
        state     <= HDR;
        bit_cnt   <= '0;
        frame_idx <= '0;
        frame_err <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          HDR: begin
            if (!load_s) begin
              frame_err <= 1'b1;
              state     <= ERR;
            end else if (sclk_rise) begin
              n_prof <= hdr_next;
              if (bit_cnt == 8'd4) begin
                bit_cnt <= '0;
                if (hdr_ok) begin
                  state <= DATA;
                end else begin
                  frame_err <= 1'b1;
                  state     <= ERR;
                end
              end else begin
                bit_cnt <= bit_cnt + 8'd1;
              end
            end
          end
          DATA: begin
            if (!load_s) begin
              frame_err <= 1'b1;
              state     <= ERR;
            end else if (sclk_rise) begin
              shift <= frame_next;
              if (bit_cnt == 8'(FRAME_BITS - 1)) begin
                bit_cnt   <= '0;
                wr_en     <= 1'b1;
                wr_addr   <= frame_idx;
                wr_data   <= frame_next;
                frame_idx <= frame_idx + 5'd1;
                if (frame_idx + 5'd1 == n_prof) begin
                  sweep_total <= n_prof;
                  load_done   <= 1'b1;
                  state       <= DONE;
                end
              end else begin
                bit_cnt <= bit_cnt + 8'd1;
              end
            end
          end
          DONE: if (!load_s) state <= IDLE;
          ERR:  if (!load_s) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rabbit_profile_loader.sv
// tb/tb_rabbit_profile_loader.sv - directed self-checking bench for rabbit_profile_loader
`timescale 1ns/1ps
module tb_rabbit_profile_loader;

  logic         clk = 1'b0;
  logic         rst_n, sclk, sdio, load;
  logic         wr_en, load_done, frame_err;
  logic [4:0]   wr_addr, sweep_total;
  logic [0:183] wr_data;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_wo_wr = 0;
  logic [4:0]   log_addr [0:63];
  logic [0:183] log_data [0:63];

  always #50 clk = ~clk;

  rabbit_profile_loader #(.MAX_PROF(20), .FRAME_BITS(184)) dut (
    .ten_MHz_ext(clk), .key_2_reset(rst_n), .SCLK_PE_3(sclk), .SDIO_PE_5(sdio),
    .LOAD_PE_1(load), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sweep_total(sweep_total), .load_done(load_done), .frame_err(frame_err)
  );

  // Write/done recorder; one entry per cycle of wr_en high.
  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 64) begin
        log_addr[wr_cnt] = wr_addr;
        log_data[wr_cnt] = wr_data;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (load_done) begin
      done_cnt = done_cnt + 1;
      if (!wr_en) done_wo_wr = done_wo_wr + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdio = b;
    wait_clk(4);
    sclk = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
  endtask

  task automatic send_hdr(input logic [4:0] n);
    for (int i = 4; i >= 0; i--) send_bit(n[i]);
  endtask

  task automatic send_frame(input logic [0:183] f);
    for (int i = 0; i < 184; i++) send_bit(f[i]);
  endtask

  task automatic start_session(input logic [4:0] n);
    load = 1'b1;
    wait_clk(6);
    send_hdr(n);
  endtask

  task automatic end_session();
    load = 1'b0;
    wait_clk(6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; sclk = 1'b0; sdio = 1'b0;
    wait_clk(3);
    checks++; if ({wr_en, load_done, frame_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {wr_en, load_done, frame_err}); end
    checks++; if (wr_addr !== 5'd0 || sweep_total !== 5'd0) begin failures++; $display("FAIL reset_addr_total got=%0d/%0d exp=0/0", wr_addr, sweep_total); end
    checks++; if (wr_data !== 184'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", wr_data); end
    rst_n = 1'b1;
    wait_clk(3);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    wait_clk(3);
    checks++; if (wr_cnt !== 0 || frame_err !== 1'b0) begin failures++; $display("FAIL idle_ignores_sclk writes=%0d err=%b exp=0/0", wr_cnt, frame_err); end
  endtask

  task automatic test_two_frames();
    logic [0:183] f0, f1;
    int b, d;
    for (int i = 0; i < 184; i++) f0[i] = (i % 2 == 0);
    f1 = '1;
    b = wr_cnt; d = done_cnt;
    start_session(5'd2);
    send_frame(f0);
    wait_clk(2);
    checks++; if (done_cnt !== d) begin failures++; $display("FAIL two_early_done got=%0d exp=%0d", done_cnt, d); end
    send_frame(f1);
    wait_clk(3);
    checks++; if (wr_cnt - b !== 2) begin failures++; $display("FAIL two_writes got=%0d exp=2", wr_cnt - b); end
    checks++; if (log_addr[b] !== 5'd0 || log_addr[b+1] !== 5'd1) begin failures++; $display("FAIL two_addrs got=%0d,%0d exp=0,1", log_addr[b], log_addr[b+1]); end
    checks++; if (log_data[b] !== f0) begin failures++; $display("FAIL two_data0 got=%h exp=%h", log_data[b], f0); end
    checks++; if (log_data[b+1] !== f1) begin failures++; $display("FAIL two_data1 got=%h exp=%h", log_data[b+1], f1); end
    checks++; if (done_cnt - d !== 1 || done_wo_wr !== 0) begin failures++; $display("FAIL two_done got=%0d lone=%0d exp=1/0", done_cnt - d, done_wo_wr); end
    checks++; if (sweep_total !== 5'd2 || frame_err !== 1'b0) begin failures++; $display("FAIL two_total got=%0d err=%b exp=2/0", sweep_total, frame_err); end
    end_session();
  endtask

  task automatic test_full_20();
    logic [0:183] f;
    logic [4:0] k5;
    int b;
    b = wr_cnt;
    start_session(5'd20);
    for (int k = 0; k < 20; k++) begin
      f = '0; k5 = 5'(k); f[179:183] = k5;
      send_frame(f);
    end
    wait_clk(3);
    checks++; if (wr_cnt - b !== 20) begin failures++; $display("FAIL full_writes got=%0d exp=20", wr_cnt - b); end
    for (int k = 0; k < 20; k++) begin
      f = '0; k5 = 5'(k); f[179:183] = k5;
      checks++; if (log_addr[b+k] !== k5 || log_data[b+k] !== f) begin failures++; $display("FAIL full_slot%0d addr=%0d data=%h exp_addr=%0d exp_data=%h", k, log_addr[b+k], log_data[b+k], k5, f); end
    end
    checks++; if (sweep_total !== 5'd20) begin failures++; $display("FAIL full_total got=%0d exp=20", sweep_total); end
    end_session();
  endtask

  task automatic test_bad_header(input logic [4:0] n);
    int b;
    b = wr_cnt;
    start_session(n);
    wait_clk(3);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL badhdr%0d_err got=%b exp=1", n, frame_err); end
    for (int i = 0; i < 190; i++) send_bit(1'b1);
    wait_clk(3);
    checks++; if (wr_cnt !== b) begin failures++; $display("FAIL badhdr%0d_writes got=%0d exp=0", n, wr_cnt - b); end
    checks++; if (sweep_total !== 5'd20) begin failures++; $display("FAIL badhdr%0d_total got=%0d exp=20", n, sweep_total); end
    end_session();
  endtask

  task automatic test_abort();
    logic [0:183] f;
    int b, d;
    for (int i = 0; i < 184; i++) f[i] = (i % 4 == 1);
    b = wr_cnt; d = done_cnt;
    start_session(5'd3);
    send_frame(f);
    for (int i = 0; i < 100; i++) send_bit(1'b1);
    load = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 100; i++) send_bit(1'b0);
    wait_clk(3);
    checks++; if (wr_cnt - b !== 1 || log_addr[b] !== 5'd0 || log_data[b] !== f) begin failures++; $display("FAIL abort_write got=%0d addr=%0d exp=1/0", wr_cnt - b, log_addr[b]); end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL abort_err got=%b exp=1", frame_err); end
    checks++; if (done_cnt !== d || sweep_total !== 5'd20) begin failures++; $display("FAIL abort_done_total done=%0d total=%0d exp=0/20", done_cnt - d, sweep_total); end
  endtask

  task automatic test_reset_mid();
    logic [0:183] f;
    int b, d;
    for (int i = 0; i < 184; i++) f[i] = (i % 3 == 0);
    b = wr_cnt;
    start_session(5'd1);
    for (int i = 0; i < 50; i++) send_bit(1'b1);
    rst_n = 1'b0; load = 1'b0;
    #30;
    checks++; if ({wr_en, load_done, frame_err} !== 3'b000 || wr_addr !== 5'd0) begin failures++; $display("FAIL midrst_flags got=%b addr=%0d exp=000/0", {wr_en, load_done, frame_err}, wr_addr); end
    checks++; if (sweep_total !== 5'd0 || wr_data !== 184'd0) begin failures++; $display("FAIL midrst_total_data total=%0d data=%h exp=0/0", sweep_total, wr_data); end
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    for (int i = 0; i < 200; i++) send_bit(1'b1);
    wait_clk(3);
    checks++; if (wr_cnt !== b || done_cnt !== d + 0 && 0) begin failures++; $display("FAIL midrst_partial writes=%0d exp=0", wr_cnt - b); end
    d = done_cnt;
    start_session(5'd1);
    send_frame(f);
    wait_clk(3);
    checks++; if (wr_cnt - b !== 1 || log_addr[b] !== 5'd0 || log_data[b] !== f) begin failures++; $display("FAIL midrst_new_write got=%0d addr=%0d exp=1/0", wr_cnt - b, log_addr[b]); end
    checks++; if (sweep_total !== 5'd1 || done_cnt - d !== 1) begin failures++; $display("FAIL midrst_total got=%0d done=%0d exp=1/1", sweep_total, done_cnt - d); end
  endtask

  task automatic test_done_ignore();
    logic [0:183] f, g;
    int b;
    for (int i = 0; i < 184; i++) f[i] = (i % 3 == 0);
    for (int i = 0; i < 184; i++) g[i] = (i < 92);
    b = wr_cnt;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    wait_clk(3);
    checks++; if (wr_cnt !== b) begin failures++; $display("FAIL done_extra_writes got=%0d exp=0", wr_cnt - b); end
    checks++; if (wr_data !== f || wr_addr !== 5'd0) begin failures++; $display("FAIL done_hold data=%h addr=%0d exp=%h/0", wr_data, wr_addr, f); end
    end_session();
    start_session(5'd0);
    end_session();
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL second_pre_err got=%b exp=1", frame_err); end
    b = wr_cnt;
    start_session(5'd2);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL second_err_clear got=%b exp=0", frame_err); end
    send_frame(g);
    send_frame(f);
    wait_clk(3);
    checks++; if (wr_cnt - b !== 2 || log_data[b] !== g || log_data[b+1] !== f || log_addr[b+1] !== 5'd1) begin failures++; $display("FAIL second_writes got=%0d exp=2", wr_cnt - b); end
    checks++; if (sweep_total !== 5'd2) begin failures++; $display("FAIL second_total got=%0d exp=2", sweep_total); end
    end_session();
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_full_20();
    test_bad_header(5'd0);
    test_bad_header(5'd21);
    test_abort();
    test_reset_mid();
    test_done_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rabbit_profile_loader.md
RABBIT_PROFILE_LOADER -- requirements
Module: rabbit_profile_loader

Interface
REQ-001 SHALL define parameter MAX_PROF, default 20, meaning the maximum number of 184-bit profile frames per load session.
REQ-002 SHALL define parameter FRAME_BITS, default 184, meaning the payload bits per profile frame.
REQ-003 SHALL have port ten_MHz_ext, input, 1 bit: the single system clock; all logic rising-edge.
REQ-004 SHALL have port key_2_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port SCLK_PE_3, input, 1 bit: serial clock from the Rabbit, asynchronous to ten_MHz_ext.
REQ-006 SHALL have port SDIO_PE_5, input, 1 bit: serial data from the Rabbit, MSB first.
REQ-007 SHALL have port LOAD_PE_1, input, 1 bit: session frame from the Rabbit, high for a whole load session.
REQ-008 SHALL have port wr_en, output, 1 bit: one-cycle strobe that writes a completed frame into the profile store.
REQ-009 SHALL have port wr_addr, output, 5 bits: profile slot index (0..MAX_PROF-1) for the wr_en write.
REQ-010 SHALL have port wr_data, output, 184 bits ([0:183]): completed frame; bit 0 is the first bit received.
REQ-011 SHALL have port sweep_total, output, 5 bits: profile count from the last successful session.
REQ-012 SHALL have port load_done, output, 1 bit: one-cycle pulse on successful session completion.
REQ-013 SHALL have port frame_err, output, 1 bit: sticky error flag, cleared at the start of the next session.

Function
REQ-014 SHALL pass SCLK_PE_3, SDIO_PE_5 and LOAD_PE_1 each through two synchronizer flops; all decisions use synchronized copies only.
REQ-015 SHALL detect a serial bit when synchronized SCLK is 1 and was 0 in the previous cycle, and sample synchronized SDIO in that same cycle.
REQ-016 SHALL require SCLK high and low phases of at least 3 ten_MHz_ext periods each; behaviour with faster SCLK is undefined.
REQ-017 SHALL implement states IDLE, HDR, DATA, DONE and ERR.
REQ-018 SHALL move from any state to HDR on a synchronized LOAD rising edge, clearing bit_cnt, frame_idx and frame_err.
REQ-019 In HDR, SHALL shift in 5 bits MSB first as N, then go to DATA if 1<=N<=MAX_PROF, else go to ERR.
REQ-020 In DATA, SHALL shift bits into a 184-bit register with an 8-bit bit_cnt counting 0..183.
REQ-021 On the 184th bit, SHALL assert wr_en for exactly one cycle, in the cycle after that bit's edge-detect cycle.
REQ-022 With that wr_en, SHALL present wr_addr equal to frame_idx and wr_data equal to the full frame, then increment frame_idx and wrap bit_cnt to 0.
REQ-023 SHALL hold wr_data and wr_addr stable between strobes.
REQ-024 When frame_idx reaches N after a write, SHALL load sweep_total with N, pulse load_done in the same cycle as that final wr_en, and enter DONE.
REQ-025 In DONE, SHALL ignore further SCLK edges with no writes, and return to IDLE when LOAD falls.
REQ-026 If LOAD falls in HDR or DATA, SHALL set frame_err, enter ERR, and leave sweep_total unchanged.
REQ-027 Slots already written before an abort SHALL remain written; no write SHALL occur for a partial frame.
REQ-028 In ERR, SHALL ignore SCLK and return to IDLE when LOAD is low.
REQ-029 In IDLE, SHALL ignore SCLK edges.
REQ-030 SHALL give a LOAD rising edge priority over a simultaneous SCLK edge; that SCLK edge is discarded.

Reset
REQ-031 On key_2_reset low, SHALL immediately force state IDLE and set wr_en, load_done, frame_err, wr_addr, wr_data, sweep_total, bit_cnt, frame_idx and all synchronizer flops to 0.
REQ-032 On release of reset, SHALL require a new LOAD rising edge before any bit is accepted.
REQ-033 If reset is asserted mid-session, SHALL accept no partial frame and raise no load_done after release.

Verification
REQ-034 Bench SHALL check: N=2 header (00010), then two frames of alternating 1010... and all-ones -> wr_en at addr 0 then 1 with matching wr_data, load_done with the 2nd write, sweep_total=2.
REQ-035 Bench SHALL check: N=20 with frame k holding k in bits [179:183] -> 20 writes at addrs 0..19, sweep_total=20.
REQ-036 Bench SHALL check: headers N=0 and N=21 -> frame_err=1, no wr_en, sweep_total keeps its prior value.
REQ-037 Bench SHALL check: N=3, LOAD dropped after 100 bits of frame 1 -> exactly one write (addr 0), frame_err=1, no load_done, sweep_total unchanged.
REQ-038 Bench SHALL check: key_2_reset pulsed low mid-frame, then a new N=1 session -> outputs 0 during reset, then one write at addr 0, sweep_total=1.
REQ-039 Bench SHALL check: 10 extra SCLK edges in DONE -> no writes; a second session after LOAD toggles loads normally and clears frame_err.
